// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 size codes (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
//   - FSM state enum
//   - size_bytes(): byte count of an access from its funct3 code
package lsu_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   // Unknown codes report 1 byte; they are rejected separately by the checker.
   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3)
         SZ_H, SZ_HU: return 3'd2;
         SZ_W:        return 3'd4;
         default:     return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_req_check.sv
// lsu_req_check: combinational legality check of a load/store request.
//   write   in  1   1 = store
//   funct3  in  3   size code
//   addr    in  32  byte address
//   err     out 1   request is illegal and must not reach memory
module lsu_req_check
   import lsu_pkg::*;
#(
   parameter int DATA_WORDS       = 64,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   output logic        err
);

   localparam logic [32:0] LIMIT = 33'(4 * DATA_WORDS);

   logic [32:0] last_byte;
   logic        bad_f3, bad_store, out_of_range, misaligned;

   always_comb begin
      // 33-bit sum so an access near 0xFFFFFFFF cannot wrap into range.
      last_byte    = {1'b0, addr} + 33'(size_bytes(funct3)) - 33'd1;
      bad_f3       = !(funct3 inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
      bad_store    = write && (funct3 == SZ_BU || funct3 == SZ_HU);
      out_of_range = (last_byte >= LIMIT);
      misaligned   = !ALLOW_MISALIGNED &&
                     (((funct3 == SZ_H || funct3 == SZ_HU) && addr[0]) ||
                      (funct3 == SZ_W && addr[1:0] != 2'b00));
      err          = bad_f3 || bad_store || out_of_range || misaligned;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the DataMemory port.
//   req_*   valid/ready request channel from execute (write, funct3, addr, wdata, tag)
//   resp_*  valid/ready response channel (rdata, tag, err), held until taken
//   mem_*   single-cycle access to DataMemory; mem_rd_val is combinational
// One request in flight: IDLE -> ACCESS (one cycle) -> RESP, or IDLE -> RESP
// directly for illegal requests. A new request may be taken in the same cycle
// the response is consumed.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WORDS       = 64,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_tag,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_tag,
   output logic        resp_err,
   output logic [31:0] mem_access_addr,
   output logic [31:0] mem_wr_val,
   output logic        mem_write_en,
   output logic        mem_read_en,
   output logic [2:0]  mem_data_size,
   input  logic [31:0] mem_rd_val
);

   lsu_state_e  state_q, state_d;
   logic        wr_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic        req_err;
   logic        req_hs;

   lsu_req_check #(
      .DATA_WORDS       (DATA_WORDS),
      .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
   ) u_check (
      .write  (req_write),
      .funct3 (req_funct3),
      .addr   (req_addr),
      .err    (req_err)
   );

   assign req_hs = req_valid && req_ready;

   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so nothing is offered while reset is held.
            req_ready = rst_n;
            if (req_valid) state_d = req_err ? RESP : ACCESS;
         end
         ACCESS: begin
            // Enables decode straight from the state register, so an async
            // reset kills them in the same instant.
            mem_write_en = wr_q;
            mem_read_en  = !wr_q;
            state_d      = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            req_ready  = resp_ready;
            if (resp_ready) begin
               if (req_valid) state_d = req_err ? RESP : ACCESS;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_rdata <= '0;
         resp_tag   <= '0;
         resp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req_hs) begin
            wr_q       <= req_write;
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_tag   <= req_tag;
            resp_err   <= req_err;
            resp_rdata <= '0;
         end else if (state_q == ACCESS && !wr_q) begin
            resp_rdata <= mem_rd_val;
         end
      end
   end

   // Bus outputs are the request latches; they hold between accesses.
   assign mem_access_addr = addr_q;
   assign mem_wr_val      = wdata_q;
   assign mem_data_size   = f3_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts one load or store at a time from the core pipeline over a valid/ready request channel, checks legality, drives a single-cycle access on the `DataMemory` port, and returns the result on a valid/ready response channel. Sits between the execute stage and `DataMemory`.

## Interface
- `DATA_WORDS`, default 64: rows per byte bank. Addressable bytes = 4*DATA_WORDS.
- `ALLOW_MISALIGNED`, default 1: 0 makes unaligned halfword and word accesses an error.

Ports:
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low bytes used for b/h.
- `req_tag`  in  5  destination register tag, returned unchanged.
- `resp_valid`  out  1  response held until taken.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  load data as returned by memory; 0 for stores and errors.
- `resp_tag`  out  5  latched `req_tag`.
- `resp_err`  out  1  request was illegal; no memory access made.
- `mem_access_addr`  out  32  to `DataMemory`.
- `mem_wr_val`  out  32  to `DataMemory`.
- `mem_write_en`  out  1  to `DataMemory`.
- `mem_read_en`  out  1  to `DataMemory`.
- `mem_data_size`  out  3  to `DataMemory`; equals latched funct3.
- `mem_rd_val`  in  32  from `DataMemory`; combinational, already sign/zero-extended.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On handshake, latch write, funct3, addr, wdata, tag; evaluate legality. Legal -> ACCESS; illegal -> RESP with `resp_err`=1.
- Illegal when any of: funct3 not in {000,001,010,100,101}; store with funct3 100/101; `addr + nbytes - 1 >= 4*DATA_WORDS` (nbytes 1/2/4, computed 33-bit, no wrap); `ALLOW_MISALIGNED`=0 and (h with addr[0]=1, or w with addr[1:0]!=0).
- ACCESS (exactly one cycle): drive `mem_access_addr`/`mem_wr_val`/`mem_data_size` from latches; `mem_write_en`=1 for store, else `mem_read_en`=1; for loads, register `mem_rd_val` into `resp_rdata` at cycle end. -> RESP.
- RESP: `resp_valid`=1, outputs stable until `resp_ready`. On take: if `req_valid`, accept next request in the same cycle (`req_ready`=resp_ready in RESP), go to ACCESS or RESP(err); else IDLE.
- Outside ACCESS: `mem_write_en`=`mem_read_en`=0; address/data/size hold latched values.

## Timing
- Reset values: `req_ready`=0 while `rst_n` low, 1 in IDLE after release; `resp_valid`, `resp_err`, `mem_write_en`, `mem_read_en`=0; `resp_rdata`, `resp_tag`, `mem_*` buses=0; state IDLE.
- Legal request accepted at edge N: ACCESS during cycle N..N+1, store commits at edge N+1, `resp_valid` high after edge N+1. Error: `resp_valid` high after edge N.
- Back-to-back peak throughput: one access per 2 cycles.
- Exactly one write-enable cycle per legal store; never on errors.
- Reset asserted in ACCESS drops `mem_write_en` immediately (asynchronous); access and pending response are discarded.
- `resp_ready` held low: response and memory outputs stay frozen indefinitely; no new request accepted.

## Structure
- Package `lsu_pkg`: funct3 size constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), state enum, byte-count function.
- One sub-module: `lsu_req_check`, combinational legality check (funct3, write, addr, parameters -> err).

## Test plan
- Store w 0xDEADBEEF at 0x10, then load w 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, one write-enable pulse.
- Store b 0x80 at 0x21, load b 0x21 -> 0xFFFFFF80; load bu 0x21 -> 0x00000080.
- Misaligned w store 0x11223344 at 0x0F (ALLOW_MISALIGNED=1), load w 0x0F -> 0x11223344; same with ALLOW_MISALIGNED=0 -> resp_err 1, no mem enable.
- Load w at 0xFD with DATA_WORDS=64 -> resp_err 1; load b at 0xFF -> legal; store funct3 100 -> resp_err 1.
- Back-to-back: resp_ready=1, req_valid held with three requests -> accepts every 2 cycles, tags returned in order.
- resp_ready low 5 cycles then high -> resp_valid held, data/tag stable; reset asserted during ACCESS of a store -> memory location unchanged.
